// File: rtl/square_node_detector.sv
// Measures the period of a sampled audio waveform and reports which generator
// note (doi..so) it matches as a one-hot code, with confirmation and silence timeout.
module square_node_detector #(
  parameter int unsigned MID      = 2048,
  parameter int unsigned HYST     = 256,
  parameter int unsigned P_MIN    = 239387,
  parameter int unsigned B_SO_FA  = 270817,
  parameter int unsigned B_FA_MI  = 294781,
  parameter int unsigned B_MI_RE  = 321583,
  parameter int unsigned B_RE_DOI = 360908,
  parameter int unsigned P_MAX    = 402452,
  parameter int unsigned CONFIRM  = 2,
  parameter int unsigned TIMEOUT  = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample,
  input  logic        sample_valid,
  output logic [4:0]  note,
  output logic        note_valid,
  output logic        note_change,
  output logic [19:0] period
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [11:0] LVL_HI    = 12'(MID + HYST);
  localparam logic [11:0] LVL_LO    = 12'(MID - HYST);
  localparam logic [19:0] CNT_MAX   = '1;
  localparam logic [2:0]  CONFIRM_N = 3'(CONFIRM);

  localparam logic [4:0] NOTE_NONE = 5'b00000;
  localparam logic [4:0] NOTE_DOI  = 5'b00001;
  localparam logic [4:0] NOTE_RE   = 5'b00010;
  localparam logic [4:0] NOTE_MI   = 5'b00100;
  localparam logic [4:0] NOTE_FA   = 5'b01000;
  localparam logic [4:0] NOTE_SO   = 5'b10000;

  state_t      state;
  logic        lvl;
  logic [19:0] count;
  logic [4:0]  cand;
  logic [2:0]  match;

  logic        rise;
  logic        timeout;
  logic        promote;
  logic [4:0]  cls;

  function automatic logic [4:0] classify(input logic [19:0] p);
    logic [4:0] c;
    if (p < 20'(P_MIN) || p >= 20'(P_MAX)) c = NOTE_NONE;
    else if (p < 20'(B_SO_FA))             c = NOTE_SO;
    else if (p < 20'(B_FA_MI))             c = NOTE_FA;
    else if (p < 20'(B_MI_RE))             c = NOTE_MI;
    else if (p < 20'(B_RE_DOI))            c = NOTE_RE;
    else                                   c = NOTE_DOI;
    return c;
  endfunction

  // NOTE: every signal of this block is assigned on every pass, so no latch can be inferred.
  always_comb begin
    rise    = sample_valid && !lvl && (sample >= LVL_HI);
    timeout = (state == MEASURE) && (count >= 20'(TIMEOUT));
    cls     = classify(count);
    promote = (match == CONFIRM_N) && (cand != note);
  end

  // count restarts at 1 on a rising event so that at the next rising event it
  // holds exactly the number of cycles between the two.
  // NOTE: non-blocking assignments throughout; a later assignment in this block
  // (e.g. the count restart) overrides the default free-running increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lvl         <= 1'b0;
      count       <= '0;
      period      <= '0;
      cand        <= NOTE_NONE;
      match       <= '0;
      note        <= NOTE_NONE;
      note_valid  <= 1'b0;
      note_change <= 1'b0;
    end else begin
      if (sample_valid) begin
        if (!lvl && sample >= LVL_HI)     lvl <= 1'b1;
        else if (lvl && sample <= LVL_LO) lvl <= 1'b0;
      end

      count       <= (count == CNT_MAX) ? count : count + 20'd1;
      note_change <= 1'b0;

      if (timeout) begin
        // Silence wins over any pending confirmation; a coincident edge only re-arms.
        state       <= IDLE;
        cand        <= NOTE_NONE;
        match       <= '0;
        note        <= NOTE_NONE;
        note_valid  <= 1'b0;
        note_change <= (note != NOTE_NONE);
        if (rise) begin
          state <= MEASURE;
          count <= 20'd1;
        end
      end else begin
        if (rise) begin
          state <= MEASURE;
          count <= 20'd1;
          if (state == MEASURE) begin
            period <= count;
            if (cls == cand) begin
              match <= (match >= CONFIRM_N) ? CONFIRM_N : match + 3'd1;
            end else begin
              cand  <= cls;
              match <= 3'd1;
            end
          end
        end
        if (promote) begin
          note        <= cand;
          note_valid  <= (cand != NOTE_NONE);
          note_change <= 1'b1;
        end
      end
    end
  end

endmodule
